load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 64 ++++++
 rtl/load_align.sv | 28 ++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Width codes, FSM encoding and store lane helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } lsu_state_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } st_lanes_t;

  function automatic logic op_legal(
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      f3 == F3_B:  ok = 1'b1;
      f3 == F3_H:  ok = !a[0];
      f3 == F3_W:  ok = (a == 2'b00);
      f3 == F3_BU: ok = !st;
      f3 == F3_HU: ok = !st && !a[0];
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic st_lanes_t store_lanes(
    input logic [2:0]  f3,
    input logic [1:0]  a,
    input logic [31:0] d
  );
    st_lanes_t l;
    l.wdata = d;
    l.wstrb = 4'b1111;
    unique case (1'b1)
      f3 == F3_B: begin
        l.wdata = {4{d[7:0]}};
        l.wstrb = 4'b0001 << a;
      end
      f3 == F3_H: begin
        l.wdata = {2{d[15:0]}};
        l.wstrb = a[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a read word
// and sign- or zero-extends it to 32 bits.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'(rdata >> {addr_lo, 3'b000});
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data = rdata;
    unique case (1'b1)
      funct3 == F3_B:  data = {{24{b[7]}}, b};
      funct3 == F3_H:  data = {{16{h[15]}}, h};
      funct3 == F3_BU: data = {24'd0, b};
      funct3 == F3_HU: data = {16'd0, h};
      default:         data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one op at a time,
// drives the data bus, times out stuck accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_wr_en,
  output logic [4:0]  wb_rdId,
  output logic [31:0] wb_rd_data,
  output logic        misaligned,
  output logic        bus_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t    state;
  logic [CW-1:0] cnt;
  logic          st_q;
  logic [2:0]    f3_q;
  logic [1:0]    alo_q;
  logic [4:0]    rd_q;
  logic          legal;
  st_lanes_t     lanes;
  logic [31:0]   ld_data;

  assign req_ready = (state == S_IDLE);
  assign legal = op_legal(req_is_store, req_funct3,
                          req_addr[1:0]);
  assign lanes = store_lanes(req_funct3, req_addr[1:0],
                             req_wdata);

  load_align u_align (
    .rdata   (mem_rdata),
    .addr_lo (alo_q),
    .funct3  (f3_q),
    .data    (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      st_q       <= 1'b0;
      f3_q       <= '0;
      alo_q      <= '0;
      rd_q       <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      wb_wr_en   <= 1'b0;
      wb_rdId    <= '0;
      wb_rd_data <= '0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      wb_wr_en   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            st_q  <= req_is_store;
            f3_q  <= req_funct3;
            alo_q <= req_addr[1:0];
            rd_q  <= req_rd;
            if (!legal) begin
              misaligned <= 1'b1;
            end else begin
              state     <= S_ACCESS;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_is_store;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= req_is_store ? lanes.wdata : '0;
              mem_wstrb <= req_is_store ? lanes.wstrb : '0;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            if (st_q) begin
              state <= S_IDLE;
            end else begin
              state      <= S_DONE;
              wb_wr_en   <= (rd_q != 5'd0);
              wb_rdId    <= rd_q;
              wb_rd_data <= ld_data;
            end
          end else if (cnt == LIMIT) begin
            // Stuck bus: abandon the access, no write-back.
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            bus_error <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed
// vector table, corner sequences and random ops.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_wr_en;
  logic [4:0]  wb_rdId;
  logic [31:0] wb_rd_data;
  logic        misaligned, bus_error;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit        st;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [4:0]  rd;
    bit [31:0] rdata;
    int        lat;
    bit        legal;
    bit [31:0] maddr;
    bit [31:0] mwdata;
    bit [3:0]  strb;
    bit [31:0] res;
  } vec_t;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .wb_wr_en(wb_wr_en), .wb_rdId(wb_rdId),
    .wb_rd_data(wb_rd_data),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    bit st, bit [2:0] f3, bit [31:0] addr,
    bit [31:0] wdata, bit [4:0] rd, bit [31:0] rdata,
    int lat, bit legal, bit [31:0] maddr,
    bit [31:0] mwdata, bit [3:0] strb, bit [31:0] res);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr;
    v.wdata = wdata; v.rd = rd; v.rdata = rdata;
    v.lat = lat; v.legal = legal; v.maddr = maddr;
    v.mwdata = mwdata; v.strb = strb; v.res = res;
    return v;
  endfunction

  // Reference: access size, alignment and extension
  // worked out arithmetically from the ISA rules.
  function automatic void model(inout vec_t v);
    int sz;
    bit sgn;
    bit [31:0] a, lim, sh;
    sz = 0;
    sgn = 0;
    case (v.f3)
      3'd0: begin sz = 1; sgn = 1; end
      3'd1: begin sz = 2; sgn = 1; end
      3'd2: sz = 4;
      3'd4: if (!v.st) sz = 1;
      3'd5: if (!v.st) sz = 2;
      default: sz = 0;
    endcase
    a = v.addr % 4;
    v.legal = (sz != 0) && ((v.addr % sz) == 0);
    v.maddr = v.addr - a;
    v.mwdata = 0;
    v.strb = 0;
    v.res = 0;
    if (sz == 0) return;
    lim = (sz == 4) ? 0 : (32'd1 << (8 * sz));
    if (v.st) begin
      v.strb = 4'(((32'd1 << sz) - 1) << a);
      if (sz == 4) v.mwdata = v.wdata;
      else if (sz == 2)
        v.mwdata = (v.wdata % lim) * 32'h0001_0001;
      else
        v.mwdata = (v.wdata % lim) * 32'h0101_0101;
    end else begin
      sh = v.rdata >> (8 * a);
      if (sz == 4) v.res = v.rdata;
      else begin
        v.res = sh % lim;
        if (sgn && v.res >= lim / 2) v.res = v.res - lim;
      end
    end
  endfunction

  task automatic run_op(input vec_t v, input string nm);
    bit fin, comp, tmo;
    @(negedge clk);
    chk({nm, " ready_idle"}, 32'(req_ready), 1);
    req_valid = 1'b1;
    req_is_store = v.st;
    req_funct3 = v.f3;
    req_addr = v.addr;
    req_wdata = v.wdata;
    req_rd = v.rd;
    @(negedge clk);
    req_valid = 1'b0;
    req_is_store = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    req_rd = 5'($urandom);
    if (!v.legal) begin
      chk({nm, " misal"}, 32'(misaligned), 1);
      chk({nm, " rej_req"}, 32'(mem_req), 0);
      chk({nm, " rej_wb"}, 32'(wb_wr_en), 0);
      @(negedge clk);
      chk({nm, " misal_end"}, 32'(misaligned), 0);
      chk({nm, " rej_req2"}, 32'(mem_req), 0);
      return;
    end
    chk({nm, " no_misal"}, 32'(misaligned), 0);
    fin = 0;
    comp = 0;
    tmo = 0;
    for (int c = 0; c < TO && !fin; c++) begin
      chk({nm, " req"}, 32'(mem_req), 1);
      chk({nm, " addr"}, mem_addr, v.maddr);
      chk({nm, " we"}, 32'(mem_we), 32'(v.st));
      chk({nm, " strb"}, 32'(mem_wstrb), 32'(v.strb));
      if (v.st) chk({nm, " wdata"}, mem_wdata, v.mwdata);
      chk({nm, " busy"}, 32'(req_ready), 0);
      chk({nm, " wb_early"}, 32'(wb_wr_en), 0);
      comp = (c == v.lat);
      tmo = !comp && (c == TO - 1);
      mem_ready = comp;
      mem_rdata = comp ? v.rdata : $urandom;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      fin = comp || tmo;
    end
    if (!fin) chk({nm, " no_end"}, 0, 1);
    else if (tmo) begin
      chk({nm, " buserr"}, 32'(bus_error), 1);
      chk({nm, " tmo_req"}, 32'(mem_req), 0);
      chk({nm, " tmo_wb"}, 32'(wb_wr_en), 0);
      chk({nm, " tmo_idle"}, 32'(req_ready), 1);
      @(negedge clk);
      chk({nm, " buserr_end"}, 32'(bus_error), 0);
    end else if (v.st) begin
      chk({nm, " st_req"}, 32'(mem_req), 0);
      chk({nm, " st_wb"}, 32'(wb_wr_en), 0);
      chk({nm, " st_idle"}, 32'(req_ready), 1);
    end else begin
      chk({nm, " wb_en"}, 32'(wb_wr_en), 32'(v.rd != 0));
      chk({nm, " wb_rd"}, 32'(wb_rdId), 32'(v.rd));
      chk({nm, " wb_data"}, wb_rd_data, v.res);
      chk({nm, " ld_req"}, 32'(mem_req), 0);
      chk({nm, " ld_busy"}, 32'(req_ready), 0);
      @(negedge clk);
      chk({nm, " wb_end"}, 32'(wb_wr_en), 0);
      chk({nm, " ld_idle"}, 32'(req_ready), 1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    vec_t v;
    tbl[0]  = mk(0, 3'b000, 32'h1003, 0, 5, 32'h80FF_0000, 0,
                 1, 32'h1000, 0, 4'b0000, 32'hFFFF_FF80);
    tbl[1]  = mk(0, 3'b101, 32'h2002, 0, 6, 32'hBEEF_1234, 0,
                 1, 32'h2000, 0, 4'b0000, 32'h0000_BEEF);
    tbl[2]  = mk(1, 3'b000, 32'h3001, 32'hAB, 7, 0, 0,
                 1, 32'h3000, 32'hABAB_ABAB, 4'b0010, 0);
    tbl[3]  = mk(0, 3'b010, 32'h4002, 0, 8, 0, 0,
                 0, 0, 0, 4'b0000, 0);
    tbl[4]  = mk(0, 3'b010, 32'h5000, 0, 9, 0, 99,
                 1, 32'h5000, 0, 4'b0000, 0);
    tbl[5]  = mk(1, 3'b001, 32'h6002, 32'h1234_5678, 1, 0, 1,
                 1, 32'h6000, 32'h5678_5678, 4'b1100, 0);
    tbl[6]  = mk(1, 3'b010, 32'h7000, 32'hDEAD_BEEF, 2, 0, 2,
                 1, 32'h7000, 32'hDEAD_BEEF, 4'b1111, 0);
    tbl[7]  = mk(0, 3'b001, 32'h8000, 0, 3, 32'h0000_8001, 3,
                 1, 32'h8000, 0, 4'b0000, 32'hFFFF_8001);
    tbl[8]  = mk(0, 3'b100, 32'h9002, 0, 0, 32'h00C3_0000, 1,
                 1, 32'h9000, 0, 4'b0000, 32'h0000_00C3);
    tbl[9]  = mk(0, 3'b001, 32'hA001, 0, 4, 0, 0,
                 0, 0, 0, 4'b0000, 0);
    tbl[10] = mk(1, 3'b100, 32'hB000, 32'h55, 4, 0, 0,
                 0, 0, 0, 4'b0000, 0);
    tbl[11] = mk(0, 3'b011, 32'hB100, 0, 4, 0, 0,
                 0, 0, 0, 4'b0000, 0);
    tbl[12] = mk(0, 3'b010, 32'hC004, 0, 31, 32'h1234_5678, 1,
                 1, 32'hC004, 0, 4'b0000, 32'h1234_5678);
    tbl[13] = mk(1, 3'b001, 32'hD001, 32'h77, 4, 0, 0,
                 0, 0, 0, 4'b0000, 0);

    rst_n = 1'b0;
    req_valid = 0; req_is_store = 0; req_funct3 = 0;
    req_addr = 0; req_wdata = 0; req_rd = 0;
    mem_ready = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst ready", 32'(req_ready), 1);
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst wstrb", 32'(mem_wstrb), 0);
    chk("rst wb", 32'(wb_wr_en), 0);
    chk("rst misal", 32'(misaligned), 0);
    chk("rst buserr", 32'(bus_error), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++)
      run_op(tbl[i], $sformatf("vec%0d", i));

    // Stray mem_ready while idle must do nothing.
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      chk("stray req", 32'(mem_req), 0);
      chk("stray wb", 32'(wb_wr_en), 0);
      chk("stray ready", 32'(req_ready), 1);
    end
    mem_ready = 1'b0;

    // Reset in the middle of an access.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 0;
    req_funct3 = 3'b010; req_addr = 32'h100; req_rd = 3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid req_up", 32'(mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid req_drop", 32'(mem_req), 0);
    chk("mid ready", 32'(req_ready), 1);
    chk("mid addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(mk(0, 3'b010, 32'h200, 0, 12, 32'hCAFE_F00D, 1,
              1, 32'h200, 0, 4'b0000, 32'hCAFE_F00D),
           "post_rst");

    for (int i = 0; i < 80; i++) begin
      v.st = 1'($urandom_range(0, 1));
      v.f3 = 3'($urandom_range(0, 7));
      v.addr = $urandom;
      v.wdata = $urandom;
      v.rd = 5'($urandom);
      v.rdata = $urandom;
      v.lat = $urandom_range(0, 5);
      model(v);
      run_op(v, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
